// File: rtl/seq_detector_pkg.sv
// Shared sizing helpers for the programmable sequence detector.
package seq_detector_pkg;

  // Bits needed to hold a pattern length from 0 up to max_len inclusive.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear with a simultaneous increment yields 1.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? CNT_W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating match count.
module seq_detector_prog
  import seq_detector_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]    cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  input  logic                         x_valid,
  input  logic                         x,
  output logic                         z,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         armed
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               match;

  assign armed = (len != '0);

  always_comb begin
    accept    = x_valid && !cfg_we && armed;
    hist_next = {hist[MAX_LEN-2:0], x};
    fill_inc  = (fill < len) ? fill + 1'b1 : len;
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len));
    end
    // Only the low len bits take part; older history and pattern bits are don't-care.
    match = accept && (fill_inc == len) && (((hist_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else if (cfg_we) begin
      pattern <= cfg_pattern;
      len     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else if (accept) begin
      hist <= hist_next;
      fill <= (match && !overlap) ? '0 : fill_inc;
      z    <= match;
    end else begin
      z <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(match),
    .q  (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a default instance plus a 2-bit counter instance sharing stimulus.
module tb_seq_detector_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        x_valid = 1'b0;
  logic        x = 1'b0;

  logic        z, armed, z2, armed2;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .x_valid(x_valid), .x(x), .z(z), .match_cnt(match_cnt), .armed(armed)
  );

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .x_valid(x_valid), .x(x), .z(z2), .match_cnt(match_cnt2), .armed(armed2)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    x_valid = 1'b1;
    x = b;
    cyc();
    x_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic clr);
    cfg_we = 1'b1;
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ovl;
    cnt_clr = clr;
    cyc();
    cfg_we = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (z !== 1'b0 || armed !== 1'b0 || match_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: z=%b armed=%b cnt=%0d, expected z=0 armed=0 cnt=0", z, armed, match_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1);
      checks++;
      if (z !== 1'b0 || armed !== 1'b0 || match_cnt !== 16'd0) begin
        errors++;
        $display("FAIL unarmed_bit%0d: z=%b armed=%b cnt=%0d, expected 0/0/0", i, z, armed, match_cnt);
      end
    end
  endtask

  task automatic test_overlap();
    logic [7:0] bits;
    logic [7:0] exp_z;
    bits  = 8'b1001_0010;
    exp_z = 8'b0000_1001;
    // Upper pattern bits set to exercise the length mask.
    load_cfg(8'hF2, 4'd5, 1'b1, 1'b1);
    checks++;
    if (armed !== 1'b1 || z !== 1'b0) begin
      errors++;
      $display("FAIL ovl_load: armed=%b z=%b, expected armed=1 z=0", armed, z);
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (z !== exp_z[i]) begin
        errors++;
        $display("FAIL ovl_z_bit%0d: z=%b, expected %b", 8 - i, z, exp_z[i]);
      end
    end
    checks++;
    if (match_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ovl_cnt: cnt=%0d, expected 2", match_cnt);
    end
  endtask

  task automatic test_no_overlap();
    logic [7:0] bits;
    logic [7:0] exp_z;
    bits  = 8'b1001_0010;
    exp_z = 8'b0000_1000;
    load_cfg(8'h12, 4'd5, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (z !== exp_z[i]) begin
        errors++;
        $display("FAIL novl_z_bit%0d: z=%b, expected %b", 8 - i, z, exp_z[i]);
      end
    end
    checks++;
    if (match_cnt !== 16'd1) begin
      errors++;
      $display("FAIL novl_cnt: cnt=%0d, expected 1", match_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [2:0] bits;
    bits = 3'b101;
    load_cfg(8'h05, 4'd3, 1'b1, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      send_bit(bits[i]);
      checks++;
      if (z !== (i == 0)) begin
        errors++;
        $display("FAIL gap_z_bit%0d: z=%b, expected %b", 3 - i, z, (i == 0));
      end
      cyc();
      checks++;
      if (z !== 1'b0) begin
        errors++;
        $display("FAIL gap_idle%0d: z=%b, expected 0", 3 - i, z);
      end
    end
    checks++;
    if (match_cnt !== 16'd1) begin
      errors++;
      $display("FAIL gap_cnt: cnt=%0d, expected 1", match_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [6];
    exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset(1);
    checks++;
    if (match_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL sat_reset: cnt=%0d, expected 0", match_cnt2);
    end
    load_cfg(8'h03, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      checks++;
      if (match_cnt2 !== exp_cnt[i] || z2 !== (i != 0)) begin
        errors++;
        $display("FAIL sat_bit%0d: cnt=%0d z=%b, expected cnt=%0d z=%b", i + 1, match_cnt2, z2, exp_cnt[i], (i != 0));
      end
    end
    cnt_clr = 1'b1;
    send_bit(1'b1);
    cnt_clr = 1'b0;
    checks++;
    if (match_cnt2 !== 2'd1 || match_cnt !== 16'd1 || z2 !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_match: cnt2=%0d cnt=%0d z=%b, expected 1/1/1", match_cnt2, match_cnt, z2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pre;
    logic [7:0] bits8;
    pre = 4'b1001;
    // Reload mid-sequence, with a valid bit offered in the same cycle that must be dropped.
    load_cfg(8'h12, 4'd5, 1'b1, 1'b1);
    for (int i = 3; i >= 0; i--) send_bit(pre[i]);
    x_valid = 1'b1;
    x = 1'b0;
    load_cfg(8'h12, 4'd5, 1'b1, 1'b0);
    x_valid = 1'b0;
    send_bit(1'b0);
    checks++;
    if (z !== 1'b0 || match_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reload_mid_seq: z=%b cnt=%0d, expected z=0 cnt=0", z, match_cnt);
    end
    // Reset mid-sequence.
    load_cfg(8'h12, 4'd5, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) send_bit(pre[i]);
    do_reset(1);
    checks++;
    if (z !== 1'b0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_seq: z=%b armed=%b, expected 0/0", z, armed);
    end
    load_cfg(8'h12, 4'd5, 1'b1, 1'b0);
    send_bit(1'b0);
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_seq_tail: z=%b, expected 0", z);
    end
    // Over-length config clamps to 8.
    bits8 = 8'b1011_0011;
    load_cfg(8'hB3, 4'd12, 1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits8[i]);
      checks++;
      if (z !== (i == 0)) begin
        errors++;
        $display("FAIL clamp_z_bit%0d: z=%b, expected %b", 8 - i, z, (i == 0));
      end
    end
    checks++;
    if (match_cnt !== 16'd1) begin
      errors++;
      $display("FAIL clamp_cnt: cnt=%0d, expected 1", match_cnt);
    end
    // Length 0 disarms.
    load_cfg(8'h00, 4'd0, 1'b1, 1'b0);
    send_bit(1'b0);
    checks++;
    if (armed !== 1'b0 || z !== 1'b0 || match_cnt !== 16'd1) begin
      errors++;
      $display("FAIL len0: armed=%b z=%b cnt=%0d, expected 0/0/1", armed, z, match_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_saturate();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
